// File: rtl/vga_sprite_render.sv
// Pixel stage behind the 800x600 VGA timing block: regenerates visible-area
// coordinates, draws a bordered background and a button-driven square sprite.
module vga_sprite_render #(
  parameter int unsigned H_VIS        = 800,
  parameter int unsigned V_VIS        = 600,
  parameter int unsigned SIZE         = 32,
  parameter int unsigned STEP         = 4,
  parameter int unsigned BORDER       = 4,
  parameter int unsigned INIT_X       = 384,
  parameter int unsigned INIT_Y       = 284,
  parameter logic [11:0] FG_COLOR     = 12'hF00,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h004
) (
  input  logic        pxl_clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        rdy,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick
);

  localparam logic [10:0] STEP_W   = 11'(STEP);
  localparam logic [10:0] SIZE_W   = 11'(SIZE);
  localparam logic [10:0] BORDER_W = 11'(BORDER);
  localparam logic [10:0] XR_W     = 11'(H_VIS - BORDER);
  localparam logic [10:0] YB_W     = 11'(V_VIS - BORDER);
  localparam logic [10:0] XMAX_W   = 11'(H_VIS - SIZE);
  localparam logic [10:0] YMAX_W   = 11'(V_VIS - SIZE);

  // Button order in the vectors: {left, right, up, down}
  logic [3:0]  btn_meta_q, btn_s_q;
  logic        rdy_d_q, vsync_d_q;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q, tick_q;
  logic        rdy_fall, vs_fall;

  assign rdy_fall = rdy_d_q & ~rdy;
  assign vs_fall  = vsync_d_q & ~vsync_in;

  // 11-bit arithmetic keeps pos+STEP from overflowing before the clamp.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic dec,
                                           input logic inc, input logic [10:0] maxv);
    logic [10:0] p;
    p = {1'b0, pos};
    step_axis = pos;
    if (dec && !inc) step_axis = (p < STEP_W) ? '0 : 10'(p - STEP_W);
    else if (inc && !dec) step_axis = (p + STEP_W > maxv) ? 10'(maxv) : 10'(p + STEP_W);
  endfunction

  always_comb begin
    x_d = x_q;
    if (rdy_fall) x_d = '0;
    else if (rdy && (x_q != '1)) x_d = x_q + 10'd1;

    y_d = y_q;
    if (vs_fall) y_d = '0;
    else if (rdy_fall) y_d = y_q + 10'd1;

    box_x_d = box_x_q;
    box_y_d = box_y_q;
    if (vs_fall) begin
      box_x_d = step_axis(box_x_q, btn_s_q[3], btn_s_q[2], XMAX_W);
      box_y_d = step_axis(box_y_q, btn_s_q[1], btn_s_q[0], YMAX_W);
    end
  end

  always_comb begin
    logic [10:0] xw, yw, bxw, byw;
    xw  = {1'b0, x_q};
    yw  = {1'b0, y_q};
    bxw = {1'b0, box_x_q};
    byw = {1'b0, box_y_q};
    rgb_d = BG_COLOR;
    if (!rdy)
      rgb_d = '0;
    else if (xw < BORDER_W || xw >= XR_W || yw < BORDER_W || yw >= YB_W)
      rgb_d = BORDER_COLOR;
    else if (xw >= bxw && xw < bxw + SIZE_W && yw >= byw && yw < byw + SIZE_W)
      rgb_d = FG_COLOR;
  end

  always_ff @(posedge pxl_clk) begin
    if (rst) begin
      btn_meta_q <= '0;
      btn_s_q    <= '0;
      rdy_d_q    <= 1'b0;
      vsync_d_q  <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      box_x_q    <= 10'(INIT_X);
      box_y_q    <= 10'(INIT_Y);
      rgb_q      <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      tick_q     <= 1'b0;
    end else begin
      btn_meta_q <= {btn_left, btn_right, btn_up, btn_down};
      btn_s_q    <= btn_meta_q;
      rdy_d_q    <= rdy;
      vsync_d_q  <= vsync_in;
      x_q        <= x_d;
      y_q        <= y_d;
      box_x_q    <= box_x_d;
      box_y_q    <= box_y_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_in;
      vsync_q    <= vsync_in;
      tick_q     <= vs_fall;
    end
  end

  assign rgb        = rgb_q;
  assign hsync_out  = hsync_q;
  assign vsync_out  = vsync_q;
  assign frame_tick = tick_q;

endmodule
